// File: rtl/write_back.sv
// Write-back stage: load extraction, 32x32 register file with bypassed reads,
// retired-instruction counter and misaligned/illegal load flag.
module write_back #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr_i,
    input  logic [31:0]          alu_result_i,
    input  logic [31:0]          data_i,
    input  logic                 stall_i,
    input  logic [4:0]           rs1_addr_i,
    input  logic [4:0]           rs2_addr_i,
    output logic [31:0]          rs1_data_o,
    output logic [31:0]          rs2_data_o,
    output logic                 rd_wen_o,
    output logic [4:0]           rd_addr_o,
    output logic [31:0]          rd_data_o,
    output logic                 misalign_o,
    output logic [CNT_WIDTH-1:0] retired_o
);

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JLR = 7'b1100111;
    localparam logic [6:0] OP_LD  = 7'b0000011;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        is_alu;
    logic        is_load;
    logic        load_ok;
    logic [31:0] load_val;

    logic [31:0]          regs_q [32];
    logic                 misalign_q, misalign_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;

    logic unused_bits;
    assign unused_bits = ^instr_i[31:15];

    assign opcode    = instr_i[6:0];
    assign funct3    = instr_i[14:12];
    assign off       = alu_result_i[1:0];
    assign rd_addr_o = instr_i[11:7];
    assign shifted   = data_i >> {off, 3'b000};
    assign byte_v    = shifted[7:0];
    assign half_v    = off[1] ? data_i[31:16] : data_i[15:0];

    always_comb begin
        is_alu  = 1'b0;
        is_load = 1'b0;
        case (opcode)
            OP_IMM, OP_REG, OP_LUI,
            OP_AUI, OP_JAL, OP_JLR: is_alu  = 1'b1;
            OP_LD:                  is_load = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        load_ok  = 1'b0;
        load_val = '0;
        case (funct3)
            3'b000: begin
                load_ok  = 1'b1;
                load_val = {{24{byte_v[7]}}, byte_v};
            end
            3'b100: begin
                load_ok  = 1'b1;
                load_val = {24'h0, byte_v};
            end
            3'b001: begin
                load_ok  = ~off[0];
                load_val = {{16{half_v[15]}}, half_v};
            end
            3'b101: begin
                load_ok  = ~off[0];
                load_val = {16'h0, half_v};
            end
            3'b010: begin
                load_ok  = (off == 2'b00);
                load_val = data_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_data_o = '0;
        if (is_alu) begin
            rd_data_o = alu_result_i;
        end else if (is_load && load_ok) begin
            rd_data_o = load_val;
        end
    end

    assign rd_wen_o = (is_alu || (is_load && load_ok))
                    && (rd_addr_o != 5'd0) && !stall_i;

    // Same-cycle bypass lets decode see the value being written this edge.
    assign rs1_data_o = (rs1_addr_i == 5'd0) ? 32'h0 :
                        (rd_wen_o && rs1_addr_i == rd_addr_o) ? rd_data_o :
                        regs_q[rs1_addr_i];
    assign rs2_data_o = (rs2_addr_i == 5'd0) ? 32'h0 :
                        (rd_wen_o && rs2_addr_i == rd_addr_o) ? rd_data_o :
                        regs_q[rs2_addr_i];

    always_comb begin
        misalign_d = is_load && !load_ok && !stall_i;
        retired_d  = retired_q;
        if (instr_i != 32'h0 && !stall_i) begin
            retired_d = retired_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (rd_wen_o) begin
            regs_q[rd_addr_o] <= rd_data_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            misalign_q <= misalign_d;
            retired_q  <= retired_d;
        end
    end

    assign misalign_o = misalign_q;
    assign retired_o  = retired_q;

endmodule

// File: tb/tb_write_back.sv
// Randomized and directed bench for write_back against a behavioural model.
module tb_write_back;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [31:0]   instr_i = '0;
    logic [31:0]   alu_result_i = '0;
    logic [31:0]   data_i = '0;
    logic          stall_i = 1'b0;
    logic [4:0]    rs1_addr_i = '0;
    logic [4:0]    rs2_addr_i = '0;
    logic [31:0]   rs1_data_o, rs2_data_o, rd_data_o;
    logic          rd_wen_o, misalign_o;
    logic [4:0]    rd_addr_o;
    logic [CW-1:0] retired_o;

    int nvec = 0;
    int nerr = 0;

    logic [31:0]   m_regs [32];
    logic [CW-1:0] exp_cnt = '0;
    logic          exp_mis = 1'b0;

    write_back #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .instr_i(instr_i),
        .alu_result_i(alu_result_i), .data_i(data_i), .stall_i(stall_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
        .rd_wen_o(rd_wen_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
        .misalign_o(misalign_o), .retired_o(retired_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] op,
                                       input logic [2:0] f3,
                                       input logic [4:0] rd);
        return {17'h0, f3, rd, op};
    endfunction

    // Spec-level model: which value an instruction writes, if any.
    function automatic void model_eval(input logic [31:0] ins, alu, dat,
                                       input logic st, output logic w,
                                       output logic [31:0] v, output logic bad);
        int o;
        logic [31:0] b, h;
        logic [6:0] op;
        o   = int'(alu[1:0]);
        op  = ins[6:0];
        w   = 1'b0;
        v   = 32'h0;
        bad = 1'b0;
        b   = (dat >> (8 * o)) & 32'hFF;
        h   = (dat >> (16 * (o / 2))) & 32'hFFFF;
        if (op == 7'h13 || op == 7'h33 || op == 7'h37 ||
            op == 7'h17 || op == 7'h6F || op == 7'h67) begin
            w = 1'b1;
            v = alu;
        end else if (op == 7'h03) begin
            case (ins[14:12])
                3'd0: begin w = 1; v = (b < 128) ? b : b + 32'hFFFF_FF00; end
                3'd4: begin w = 1; v = b; end
                3'd1: begin w = (o % 2 == 0); v = (h < 32768) ? h : h + 32'hFFFF_0000; end
                3'd5: begin w = (o % 2 == 0); v = h; end
                3'd2: begin w = (o == 0); v = dat; end
                default: w = 0;
            endcase
            bad = !w;
            if (bad) v = 32'h0;
        end
        if (ins[11:7] == 5'd0 || st) w = 1'b0;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        logic w, b;
        logic [31:0] v;
        model_eval(instr_i, alu_result_i, data_i, stall_i, w, v, b);
        if (a == 5'd0) return 32'h0;
        if (w && a == instr_i[11:7]) return v;
        return m_regs[a];
    endfunction

    task automatic drive(input logic [31:0] ins, a, d, input logic st,
                         input logic [4:0] r1, r2);
        @(negedge clk);
        instr_i = ins; alu_result_i = a; data_i = d;
        stall_i = st; rs1_addr_i = r1; rs2_addr_i = r2;
        #1;
    endtask

    task automatic commit();
        logic w, b;
        logic [31:0] v;
        @(posedge clk);
        if (rst_n) begin
            model_eval(instr_i, alu_result_i, data_i, stall_i, w, v, b);
            if (w) m_regs[instr_i[11:7]] = v;
            if (instr_i != 32'h0 && !stall_i) exp_cnt = exp_cnt + 1'b1;
            exp_mis = b && !stall_i;
        end
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        exp_cnt = '0;
        exp_mis = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        nvec++; if (retired_o !== 4'h0) begin nerr++; $display("FAIL rst_cnt got %h want 0", retired_o); end
        nvec++; if (misalign_o !== 1'b0) begin nerr++; $display("FAIL rst_mis got %b want 0", misalign_o); end
        drive(mk(7'h13, 3'd0, 5'd4), 32'h4444, 32'h0, 1'b0, 5'd4, 5'd9);
        nvec++; if (rd_wen_o !== 1'b1) begin nerr++; $display("FAIL rst_comb_wen got %b want 1", rd_wen_o); end
        nvec++; if (rs2_data_o !== 32'h0) begin nerr++; $display("FAIL rst_rs2 got %h want 0", rs2_data_o); end
        commit();
        drive(32'h0, 32'h0, 32'h0, 1'b0, 5'd4, 5'd0);
        nvec++; if (rs1_data_o !== 32'h0) begin nerr++; $display("FAIL rst_nowrite got %h want 0", rs1_data_o); end
        rst_n = 1'b1;
        commit();
    endtask

    task automatic test_loads();
        logic [CW-1:0] c0;
        drive(mk(7'h03, 3'd0, 5'd1), 32'h102, 32'h80FF_7F01, 1'b0, 5'd1, 5'd0);
        nvec++; if (rd_data_o !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL lb got %h want ffffffff", rd_data_o); end
        nvec++; if (rd_wen_o !== 1'b1) begin nerr++; $display("FAIL lb_wen got %b want 1", rd_wen_o); end
        commit();
        drive(mk(7'h03, 3'd4, 5'd2), 32'h102, 32'h80FF_7F01, 1'b0, 5'd1, 5'd2);
        nvec++; if (rd_data_o !== 32'h0000_00FF) begin nerr++; $display("FAIL lbu got %h want 000000ff", rd_data_o); end
        nvec++; if (rs1_data_o !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL lb_store got %h want ffffffff", rs1_data_o); end
        commit();
        drive(mk(7'h03, 3'd1, 5'd3), 32'h2, 32'h8001_1234, 1'b0, 5'd0, 5'd0);
        nvec++; if (rd_data_o !== 32'hFFFF_8001) begin nerr++; $display("FAIL lh got %h want ffff8001", rd_data_o); end
        commit();
        c0 = exp_cnt;
        drive(mk(7'h03, 3'd1, 5'd3), 32'h1, 32'h8001_1234, 1'b0, 5'd3, 5'd0);
        nvec++; if (rd_wen_o !== 1'b0) begin nerr++; $display("FAIL lh_mis_wen got %b want 0", rd_wen_o); end
        commit();
        nvec++; if (misalign_o !== 1'b1) begin nerr++; $display("FAIL lh_mis got %b want 1", misalign_o); end
        nvec++; if (retired_o !== CW'(c0 + 1)) begin nerr++; $display("FAIL lh_mis_cnt got %h want %h", retired_o, CW'(c0 + 1)); end
        nvec++; if (rs1_data_o !== 32'hFFFF_8001) begin nerr++; $display("FAIL lh_mis_keep got %h want ffff8001", rs1_data_o); end
        drive(32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
        commit();
        nvec++; if (misalign_o !== 1'b0) begin nerr++; $display("FAIL mis_clear got %b want 0", misalign_o); end
    endtask

    task automatic test_bypass();
        drive(mk(7'h13, 3'd0, 5'd5), 32'hDEAD_BEEF, 32'h0, 1'b0, 5'd5, 5'd0);
        nvec++; if (rs1_data_o !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL bypass got %h want deadbeef", rs1_data_o); end
        commit();
        drive(32'h0, 32'h0, 32'h0, 1'b0, 5'd5, 5'd5);
        nvec++; if (rs1_data_o !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL stored got %h want deadbeef", rs1_data_o); end
        nvec++; if (rs2_data_o !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL stored2 got %h want deadbeef", rs2_data_o); end
        commit();
    endtask

    task automatic test_x0_store();
        logic [CW-1:0] c0;
        drive(mk(7'h37, 3'd0, 5'd0), 32'h1234_5000, 32'h0, 1'b0, 5'd0, 5'd0);
        nvec++; if (rd_wen_o !== 1'b0) begin nerr++; $display("FAIL x0_wen got %b want 0", rd_wen_o); end
        nvec++; if (rs1_data_o !== 32'h0) begin nerr++; $display("FAIL x0_read got %h want 0", rs1_data_o); end
        commit();
        c0 = exp_cnt;
        drive(mk(7'h23, 3'd2, 5'd8), 32'h100, 32'h0, 1'b0, 5'd0, 5'd0);
        nvec++; if (rd_wen_o !== 1'b0) begin nerr++; $display("FAIL sw_wen got %b want 0", rd_wen_o); end
        nvec++; if (rd_data_o !== 32'h0) begin nerr++; $display("FAIL sw_data got %h want 0", rd_data_o); end
        commit();
        nvec++; if (retired_o !== CW'(c0 + 1)) begin nerr++; $display("FAIL sw_cnt got %h want %h", retired_o, CW'(c0 + 1)); end
    endtask

    task automatic test_stall();
        logic [CW-1:0] c0;
        c0 = exp_cnt;
        drive(mk(7'h33, 3'd0, 5'd6), 32'h1111, 32'h0, 1'b1, 5'd6, 5'd0);
        nvec++; if (rd_wen_o !== 1'b0) begin nerr++; $display("FAIL stall_wen got %b want 0", rd_wen_o); end
        commit();
        nvec++; if (retired_o !== c0) begin nerr++; $display("FAIL stall_cnt got %h want %h", retired_o, c0); end
        drive(32'h0, 32'h0, 32'h0, 1'b0, 5'd6, 5'd0);
        nvec++; if (rs1_data_o !== m_regs[6]) begin nerr++; $display("FAIL stall_reg got %h want %h", rs1_data_o, m_regs[6]); end
        commit();
        nvec++; if (retired_o !== c0) begin nerr++; $display("FAIL bubble_cnt got %h want %h", retired_o, c0); end
    endtask

    task automatic test_random();
        logic [6:0] ops [10];
        logic [31:0] ins;
        logic w, b;
        logic [31:0] v;
        ops = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h03, 7'h23, 7'h63};
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) ins = 32'h0;
            drive(ins, $urandom, $urandom, ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) == 0) ? ins[11:7] : 5'($urandom),
                  5'($urandom));
            model_eval(instr_i, alu_result_i, data_i, stall_i, w, v, b);
            nvec++; if (rd_wen_o !== w) begin nerr++; $display("FAIL rnd_wen ins=%h got %b want %b", ins, rd_wen_o, w); end
            nvec++; if (rd_data_o !== v) begin nerr++; $display("FAIL rnd_data ins=%h got %h want %h", ins, rd_data_o, v); end
            nvec++; if (rd_addr_o !== ins[11:7]) begin nerr++; $display("FAIL rnd_rd got %h want %h", rd_addr_o, ins[11:7]); end
            nvec++; if (rs1_data_o !== exp_rd(rs1_addr_i)) begin nerr++; $display("FAIL rnd_rs1 got %h want %h", rs1_data_o, exp_rd(rs1_addr_i)); end
            nvec++; if (rs2_data_o !== exp_rd(rs2_addr_i)) begin nerr++; $display("FAIL rnd_rs2 got %h want %h", rs2_data_o, exp_rd(rs2_addr_i)); end
            commit();
            nvec++; if (misalign_o !== exp_mis) begin nerr++; $display("FAIL rnd_mis ins=%h got %b want %b", ins, misalign_o, exp_mis); end
            nvec++; if (retired_o !== exp_cnt) begin nerr++; $display("FAIL rnd_cnt got %h want %h", retired_o, exp_cnt); end
        end
    endtask

    task automatic test_reset_mid();
        drive(mk(7'h13, 3'd0, 5'd7), 32'h5, 32'h0, 1'b0, 5'd0, 5'd0);
        commit();
        drive(mk(7'h03, 3'd2, 5'd8), 32'h2, 32'h0, 1'b0, 5'd7, 5'd0);
        commit();
        nvec++; if (misalign_o !== 1'b1) begin nerr++; $display("FAIL pre_rst_mis got %b want 1", misalign_o); end
        nvec++; if (rs1_data_o !== 32'h5) begin nerr++; $display("FAIL pre_rst_x7 got %h want 5", rs1_data_o); end
        @(negedge clk);
        instr_i = mk(7'h13, 3'd0, 5'd9); alu_result_i = 32'h99;
        rs1_addr_i = 5'd7; rs2_addr_i = 5'd9;
        rst_n = 1'b0;
        model_reset();
        #1;
        nvec++; if (rs1_data_o !== 32'h0) begin nerr++; $display("FAIL rst_x7 got %h want 0", rs1_data_o); end
        nvec++; if (retired_o !== 4'h0) begin nerr++; $display("FAIL rst_mid_cnt got %h want 0", retired_o); end
        nvec++; if (misalign_o !== 1'b0) begin nerr++; $display("FAIL rst_mid_mis got %b want 0", misalign_o); end
        nvec++; if (rs2_data_o !== 32'h99) begin nerr++; $display("FAIL rst_comb got %h want 99", rs2_data_o); end
        commit();
        @(negedge clk);
        rst_n = 1'b1;
        instr_i = 32'h0;
        #1;
        nvec++; if (rs2_data_o !== 32'h0) begin nerr++; $display("FAIL rst_discard got %h want 0", rs2_data_o); end
        commit();
        drive(mk(7'h13, 3'd0, 5'd3), 32'h33, 32'h0, 1'b0, 5'd0, 5'd0);
        commit();
        drive(32'h0, 32'h0, 32'h0, 1'b0, 5'd3, 5'd0);
        nvec++; if (rs1_data_o !== 32'h33) begin nerr++; $display("FAIL first_write got %h want 33", rs1_data_o); end
        commit();
    endtask

    task automatic test_wrap();
        int base;
        base = int'(exp_cnt);
        for (int n = 0; n < 17; n++) begin
            drive(mk(7'h33, 3'd0, 5'd10), n, 32'h0, 1'b0, 5'd0, 5'd0);
            commit();
        end
        nvec++; if (retired_o !== CW'((base + 17) % 16)) begin nerr++; $display("FAIL wrap got %h want %h", retired_o, CW'((base + 17) % 16)); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_bypass();
        test_x0_store();
        test_stall();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/write_back.md
WRITE_BACK -- requirements
Module: write_back

Interface
REQ-001 Parameter CNT_WIDTH, default 32: width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 instr_i  input  32  instruction from mem_access stage; 32'h0 is a bubble.
REQ-005 alu_result_i  input  32  ALU result / effective address, or link value (pc+4) for JAL/JALR.
REQ-006 data_i  input  32  word read from data memory at {alu_result_i[31:2],2'b00}, little-endian.
REQ-007 stall_i  input  1  hold: suppresses register write, counter and error update.
REQ-008 rs1_addr_i, rs2_addr_i  input  5 each  decode-stage read addresses.
REQ-009 rs1_data_o, rs2_data_o  output  32 each  read data, combinational.
REQ-010 rd_wen_o  output  1  write enable this cycle, combinational, for forwarding.
REQ-011 rd_addr_o  output  5  destination register (instr_i[11:7]).
REQ-012 rd_data_o  output  32  value to be written.
REQ-013 misalign_o  output  1  registered one-cycle pulse on misaligned or illegal load.
REQ-014 retired_o  output  CNT_WIDTH  count of retired non-bubble instructions.

Function
REQ-015 Opcode instr_i[6:0] SHALL select the write source: OP-IMM 0010011, OP 0110011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111 -> alu_result_i; LOAD 0000011 -> extracted load data; all other opcodes -> no write.
REQ-016 Load extraction SHALL use funct3 instr_i[14:12] and offset alu_result_i[1:0]: LB/LBU select byte data_i[8*off+7:8*off], LH/LHU select halfword data_i[16*off[1]+15:16*off[1]], LW selects data_i.
REQ-017 LB and LH SHALL sign-extend to 32 bits; LBU and LHU SHALL zero-extend.
REQ-018 LH/LHU with offset bit 0 = 1, LW with offset != 0, and funct3 011/110/111 SHALL suppress the write and set misalign_o for the following cycle.
REQ-019 rd_wen_o SHALL be 1 only if the opcode writes, the load is legal, rd_addr_o != 0, and stall_i = 0.
REQ-020 Register file: 32 x 32; on rising edge with rd_wen_o = 1, reg[rd_addr_o] <= rd_data_o.
REQ-021 x0 SHALL read 0 always and never be written.
REQ-022 Read ports SHALL bypass: if rd_wen_o = 1 and rsN_addr_i == rd_addr_o, rsN_data_o = rd_data_o in the same cycle; otherwise stored value.
REQ-023 Write-to-read latency: value visible at read port in same cycle via bypass, and from storage from the next cycle.
REQ-024 retired_o SHALL increment by 1 on each edge where instr_i != 0 and stall_i = 0, including non-writing and misaligned instructions.
REQ-025 retired_o SHALL wrap from all-ones to 0 with no flag.
REQ-026 misalign_o SHALL be cleared on any edge not meeting REQ-018 conditions; stall_i = 1 forces it to 0 next cycle.
REQ-027 rd_data_o SHALL be 0 when the opcode does not write.

Reset
REQ-028 While rst_n = 0: all 31 registers, retired_o and misalign_o SHALL be 0, independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard any write pending on the next edge; first write possible on the first rising edge after rst_n deasserts.
REQ-030 Combinational outputs SHALL follow inputs during reset, but no state SHALL change.

Verification
REQ-031 LB, data_i = 32'h80FF_7F01, alu_result_i = 32'h102 -> rd_data_o = 32'hFFFF_FFFF; LBU same -> 32'h0000_00FF.
REQ-032 LH, data_i = 32'h8001_1234, alu_result_i = 32'h2 -> 32'hFFFF_8001; LH at alu_result_i = 32'h1 -> no write, misalign_o = 1 for one cycle, retired_o increments.
REQ-033 ADDI rd = 5, alu_result_i = 32'hDEAD_BEEF with rs1_addr_i = 5 -> rs1_data_o = 32'hDEAD_BEEF same cycle, and from storage next cycle.
REQ-034 LUI rd = 0, alu_result_i = 32'h1234_5000 -> rd_wen_o = 0, x0 reads 0; SW opcode -> no write, retired_o +1.
REQ-035 stall_i = 1 with valid ADD -> no write, retired_o unchanged; bubble 32'h0 -> retired_o unchanged.
REQ-036 Write x7 = 32'h5, assert rst_n = 0 between edges -> x7 reads 0, retired_o = 0, misalign_o = 0 immediately.
